arm_multicycle_controller: RTL and testbench

- Multicycle successor to the single-cycle ARM decoder: a registered FSM sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
- Sits between the instruction register / condition-check logic and the shared datapath.
- Adds a memory-ready handshake, an optional extra cycle for register-shifted-register operands, and parametrised control widths.

---
 rtl/arm_multicycle_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit. A registered FSM steps each instruction
// through fetch, decode, execute, memory and writeback, steering one shared
// ALU and one shared memory port. Strobes that depend on mem_ready are
// formed from the state register and the handshake input in the same cycle.
module arm_multicycle_controller #(
  parameter int ALU_CTRL_W   = 4,
  parameter int FLAG_W       = 4,
  parameter int EN_REG_SHIFT = 1,
  parameter int EN_BL        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            op,
  input  logic [5:0]            funct,
  input  logic [3:0]            rd,
  input  logic [7:0]            instr_lo,
  input  logic                  cond_ex,
  input  logic                  mem_ready,
  output logic [3:0]            state_out,
  output logic                  pc_write,
  output logic                  adr_src,
  output logic                  mem_req,
  output logic                  mem_w,
  output logic [2:0]            mem_select,
  output logic                  ir_write,
  output logic                  reg_w,
  output logic                  link_sel,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [1:0]            imm_src,
  output logic [1:0]            reg_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [FLAG_W-1:0]     flag_w,
  output logic [2:0]            shift_op
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_SHIFT_RS = 4'd10
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd4;
  localparam logic [2:0] SH_ROR   = 3'd3;
  localparam logic [2:0] SH_RRX   = 3'd4;
  localparam logic [2:0] SH_PASS  = 3'd5;

  // instr_lo carries instr[11:4]; instruction bit k lives at instr_lo[k-4].
  logic       reg_shift_s;
  logic       is_rrx_s;
  logic       is_cmp_test_s;
  logic       pc_write_s;
  logic       ir_write_s;
  logic       reg_w_s;
  logic       mem_w_s;
  logic       mem_req_s;
  logic       link_sel_s;
  state_t     state_r;

  // Flag-write mask for a data-processing opcode, in {N,Z,C,V} order.
  function automatic logic [3:0] dp_flags(input logic [5:0] f);
    logic [3:0] m;
    case (f[4:1])
      4'hA, 4'hB: m = 4'b1111;
      4'h8, 4'h9: m = 4'b1110;
      default:    m = {f[0], f[0], f[0], 1'b0};
    endcase
    return m;
  endfunction

  assign reg_shift_s   = (EN_REG_SHIFT != 0) && instr_lo[0] && !instr_lo[3];
  assign is_rrx_s      = (instr_lo[7:3] == 5'd0) && !instr_lo[0] && (instr_lo[2:1] == 2'b11);
  assign is_cmp_test_s = (funct[4:3] == 2'b10);
  assign state_out     = state_r;
  assign mem_select    = {1'b0, (funct[2] ? 2'b00 : 2'b10)};
  assign reg_src       = {(op == 2'b01), (op == 2'b10)};

  // Reset forces every strobe low in the cycle it is asserted.
  assign pc_write = pc_write_s & ~reset;
  assign ir_write = ir_write_s & ~reset;
  assign reg_w    = reg_w_s    & ~reset;
  assign mem_w    = mem_w_s    & ~reset;
  assign mem_req  = mem_req_s  & ~reset;
  assign link_sel = link_sel_s & ~reset;

  // State register and next-state sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      case (state_r)
        S_FETCH:    state_r <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          if (!cond_ex) begin
            state_r <= S_FETCH;
          end else begin
            case (op)
              2'b01:   state_r <= S_MEMADR;
              2'b10:   state_r <= S_BRANCH;
              2'b00: begin
                if (funct[5])         state_r <= S_EXEC_I;
                else if (reg_shift_s) state_r <= S_SHIFT_RS;
                else                  state_r <= S_EXEC_R;
              end
              default: state_r <= S_FETCH;
            endcase
          end
        end
        S_SHIFT_RS: state_r <= S_EXEC_R;
        S_EXEC_R:   state_r <= S_ALUWB;
        S_EXEC_I:   state_r <= S_ALUWB;
        S_ALUWB:    state_r <= S_FETCH;
        S_MEMADR:   state_r <= funct[0] ? S_MEMRD : S_MEMWR;
        S_MEMRD:    state_r <= mem_ready ? S_MEMWB : S_MEMRD;
        S_MEMWR:    state_r <= mem_ready ? S_FETCH : S_MEMWR;
        S_MEMWB:    state_r <= S_FETCH;
        S_BRANCH:   state_r <= S_FETCH;
        default:    state_r <= S_FETCH;
      endcase
    end
  end

  // Datapath selects and raw strobes decoded from the current state.
  always_comb begin
    pc_write_s  = 1'b0;
    ir_write_s  = 1'b0;
    reg_w_s     = 1'b0;
    mem_w_s     = 1'b0;
    mem_req_s   = 1'b0;
    link_sel_s  = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    result_src  = 2'd0;
    imm_src     = 2'd0;
    alu_control = ALU_CTRL_W'(ALU_ADD);
    flag_w      = '0;
    shift_op    = SH_PASS;
    case (state_r)
      S_FETCH: begin
        mem_req_s  = 1'b1;
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd2;
      end
      S_SHIFT_RS: begin
        alu_src_a = 2'd0;
      end
      S_EXEC_R: begin
        alu_src_b   = 2'd0;
        alu_control = ALU_CTRL_W'(funct[4:1]);
        flag_w      = FLAG_W'(dp_flags(funct));
        if (is_rrx_s) shift_op = SH_RRX;
        else          shift_op = {1'b0, instr_lo[2:1]};
      end
      S_EXEC_I: begin
        alu_src_b   = 2'd1;
        imm_src     = 2'd0;
        alu_control = ALU_CTRL_W'(funct[4:1]);
        flag_w      = FLAG_W'(dp_flags(funct));
        shift_op    = SH_ROR;
      end
      S_ALUWB: begin
        result_src = 2'd0;
        reg_w_s    = ~is_cmp_test_s;
        pc_write_s = ~is_cmp_test_s && (rd == 4'd15);
      end
      S_MEMADR: begin
        alu_src_b = 2'd1;
        imm_src   = 2'd1;
      end
      S_MEMRD: begin
        mem_req_s = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWR: begin
        mem_req_s = 1'b1;
        mem_w_s   = 1'b1;
        adr_src   = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'd1;
        reg_w_s    = 1'b1;
        pc_write_s = (rd == 4'd15);
      end
      S_BRANCH: begin
        imm_src    = 2'd2;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd1;
        pc_write_s = 1'b1;
        if ((EN_BL != 0) && funct[4]) begin
          reg_w_s    = 1'b1;
          link_sel_s = 1'b1;
        end else begin
          reg_w_s    = 1'b0;
          link_sel_s = 1'b0;
        end
      end
      default: begin
        alu_src_a = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Directed bench for arm_multicycle_controller. Each cycle's expected state,
// strobes and selects are pushed to a scoreboard queue as the stimulus is
// driven, then popped and compared mid-cycle, away from the rising edge.
module tb_arm_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [7:0] instr_lo;
  logic       cond_ex;
  logic       mem_ready;
  logic [3:0] state_out;
  logic       pc_write, adr_src, mem_req, mem_w, ir_write, reg_w, link_sel;
  logic [2:0] mem_select;
  logic [1:0] alu_src_a, alu_src_b, result_src, imm_src, reg_src;
  logic [3:0] alu_control;
  logic [3:0] flag_w;
  logic [2:0] shift_op;

  arm_multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd(rd),
    .instr_lo(instr_lo), .cond_ex(cond_ex), .mem_ready(mem_ready),
    .state_out(state_out), .pc_write(pc_write), .adr_src(adr_src),
    .mem_req(mem_req), .mem_w(mem_w), .mem_select(mem_select),
    .ir_write(ir_write), .reg_w(reg_w), .link_sel(link_sel),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
    .imm_src(imm_src), .reg_src(reg_src), .alu_control(alu_control),
    .flag_w(flag_w), .shift_op(shift_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [5:0]  stb;   // {pc_write, ir_write, reg_w, mem_w, mem_req, link_sel}
    logic        chk;
    logic [22:0] dp;    // {adr_src, a, b, result, imm, alu, flag, shift, msel}
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;

  // Select words {adr_src, alu_src_a, alu_src_b, result_src, imm_src}.
  localparam logic [8:0] M_FETCH = 9'b0_01_10_10_00;
  localparam logic [8:0] M_DEC   = 9'b0_01_10_00_00;
  localparam logic [8:0] M_EXR   = 9'b0_00_00_00_00;
  localparam logic [8:0] M_EXI   = 9'b0_00_01_00_00;
  localparam logic [8:0] M_AWB   = 9'b0_00_00_00_00;
  localparam logic [8:0] M_ADR   = 9'b0_00_01_00_01;
  localparam logic [8:0] M_MEM   = 9'b1_00_00_00_00;
  localparam logic [8:0] M_MWB   = 9'b0_00_00_01_00;
  localparam logic [8:0] M_BR    = 9'b0_00_01_00_10;

  task automatic load(input logic [31:0] instr, input logic cx);
    op       = instr[27:26];
    funct    = instr[25:20];
    rd       = instr[15:12];
    instr_lo = instr[11:4];
    cond_ex  = cx;
  endtask

  // Drive one cycle, queue its expectation, then compare what the DUT shows.
  task automatic cyc(input logic mr, input logic rs, input logic [3:0] st,
                     input logic [5:0] stb, input logic chk, input logic [8:0] mux,
                     input logic [3:0] alu, input logic [3:0] flg,
                     input logic [2:0] sh, input logic [2:0] msel, input string tag);
    exp_t e;
    exp_t got;
    logic [5:0]  stb_o;
    logic [22:0] dp_o;
    mem_ready = mr;
    reset     = rs;
    e.st  = st;
    e.stb = stb;
    e.chk = chk;
    e.dp  = {mux, alu, flg, sh, msel};
    e.tag = tag;
    exp_q.push_back(e);
    #2;
    got   = exp_q.pop_front();
    stb_o = {pc_write, ir_write, reg_w, mem_w, mem_req, link_sel};
    dp_o  = {adr_src, alu_src_a, alu_src_b, result_src, imm_src,
             alu_control, flag_w, shift_op, mem_select};
    total++;
    assert (state_out === got.st) passed++;
    else $error("FAIL %s state: got %0d expected %0d", got.tag, state_out, got.st);
    total++;
    assert (stb_o === got.stb) passed++;
    else $error("FAIL %s strobes: got %b expected %b", got.tag, stb_o, got.stb);
    if (got.chk) begin
      total++;
      assert (dp_o === got.dp) passed++;
      else $error("FAIL %s selects: got %h expected %h", got.tag, dp_o, got.dp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [2:0] msel, input string tag);
    cyc(1'b1, 1'b0, 4'd0, 6'b110010, 1'b1, M_FETCH, 4'd4, 4'd0, 3'd5, msel, {tag, "_fetch"});
    cyc(1'b1, 1'b0, 4'd1, 6'b000000, 1'b1, M_DEC,   4'd4, 4'd0, 3'd5, msel, {tag, "_decode"});
  endtask

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    load(32'hE0821003, 1'b1);
    @(posedge clk);
    #1;
    // Reset held with mem_ready high: FETCH, but no strobe may fire.
    cyc(1'b1, 1'b1, 4'd0, 6'b000000, 1'b1, M_FETCH, 4'd4, 4'd0, 3'd5, 3'b010, "reset");

    // ADD R1,R2,R3
    fetch_decode(3'b010, "add");
    cyc(1'b1, 1'b0, 4'd6, 6'b000000, 1'b1, M_EXR, 4'd4, 4'd0, 3'd0, 3'b010, "add_exec");
    cyc(1'b1, 1'b0, 4'd8, 6'b001000, 1'b1, M_AWB, 4'd4, 4'd0, 3'd5, 3'b010, "add_wb");

    // SUBS R1,R1,#1
    load(32'hE2511001, 1'b1);
    fetch_decode(3'b000, "subs");
    cyc(1'b1, 1'b0, 4'd7, 6'b000000, 1'b1, M_EXI, 4'd2, 4'b1110, 3'd3, 3'b000, "subs_exec");
    cyc(1'b1, 1'b0, 4'd8, 6'b001000, 1'b1, M_AWB, 4'd4, 4'd0, 3'd5, 3'b000, "subs_wb");

    // CMP R1,#0: all flags, no register write
    load(32'hE3510000, 1'b1);
    fetch_decode(3'b000, "cmp");
    cyc(1'b1, 1'b0, 4'd7, 6'b000000, 1'b1, M_EXI, 4'hA, 4'b1111, 3'd3, 3'b000, "cmp_exec");
    cyc(1'b1, 1'b0, 4'd8, 6'b000000, 1'b1, M_AWB, 4'd4, 4'd0, 3'd5, 3'b000, "cmp_wb");

    // LDRB R0,[R1,#4] with three wait cycles in MEMRD
    load(32'hE5D10004, 1'b1);
    fetch_decode(3'b000, "ldrb");
    cyc(1'b1, 1'b0, 4'd2, 6'b000000, 1'b1, M_ADR, 4'd4, 4'd0, 3'd5, 3'b000, "ldrb_adr");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 4'd3, 6'b000010, 1'b1, M_MEM, 4'd4, 4'd0, 3'd5, 3'b000, "ldrb_wait");
    cyc(1'b1, 1'b0, 4'd3, 6'b000010, 1'b1, M_MEM, 4'd4, 4'd0, 3'd5, 3'b000, "ldrb_rd");
    cyc(1'b1, 1'b0, 4'd4, 6'b001000, 1'b1, M_MWB, 4'd4, 4'd0, 3'd5, 3'b000, "ldrb_wb");

    // STR R0,[R1] with one fetch stall and one write wait cycle
    load(32'hE5810000, 1'b1);
    cyc(1'b0, 1'b0, 4'd0, 6'b000010, 1'b1, M_FETCH, 4'd4, 4'd0, 3'd5, 3'b010, "fetch_stall");
    fetch_decode(3'b010, "str");
    cyc(1'b1, 1'b0, 4'd2, 6'b000000, 1'b1, M_ADR, 4'd4, 4'd0, 3'd5, 3'b010, "str_adr");
    cyc(1'b0, 1'b0, 4'd5, 6'b000110, 1'b1, M_MEM, 4'd4, 4'd0, 3'd5, 3'b010, "str_wait");
    cyc(1'b1, 1'b0, 4'd5, 6'b000110, 1'b1, M_MEM, 4'd4, 4'd0, 3'd5, 3'b010, "str_wr");

    // BL taken, then the same BL with its condition failing
    load(32'hEB000010, 1'b1);
    fetch_decode(3'b010, "bl");
    cyc(1'b1, 1'b0, 4'd9, 6'b101001, 1'b1, M_BR, 4'd4, 4'd0, 3'd5, 3'b010, "bl_branch");
    load(32'hEB000010, 1'b0);
    fetch_decode(3'b010, "bl_nc");

    // op = 11 is unimplemented and returns straight to FETCH
    load(32'hEC000000, 1'b1);
    fetch_decode(3'b010, "op11");

    // ADD PC,R2,R2,RRX: RRX shift and PC write in ALUWB
    load(32'hE082F062, 1'b1);
    fetch_decode(3'b010, "rrx");
    cyc(1'b1, 1'b0, 4'd6, 6'b000000, 1'b1, M_EXR, 4'd4, 4'd0, 3'd4, 3'b010, "rrx_exec");
    cyc(1'b1, 1'b0, 4'd8, 6'b101000, 1'b1, M_AWB, 4'd4, 4'd0, 3'd5, 3'b010, "rrx_wb");

    // ADD R0,R1,R2,LSL R3 takes the SHIFT_RS cycle
    load(32'hE0810312, 1'b1);
    fetch_decode(3'b010, "rsr");
    cyc(1'b1, 1'b0, 4'd10, 6'b000000, 1'b0, M_EXR, 4'd4, 4'd0, 3'd5, 3'b010, "rsr_shift");
    cyc(1'b1, 1'b0, 4'd6, 6'b000000, 1'b1, M_EXR, 4'd4, 4'd0, 3'd0, 3'b010, "rsr_exec");
    cyc(1'b1, 1'b0, 4'd8, 6'b001000, 1'b1, M_AWB, 4'd4, 4'd0, 3'd5, 3'b010, "rsr_wb");

    // Same instruction, reset asserted in SHIFT_RS
    fetch_decode(3'b010, "rsr2");
    cyc(1'b1, 1'b1, 4'd10, 6'b000000, 1'b0, M_EXR, 4'd4, 4'd0, 3'd5, 3'b010, "rsr2_reset");
    cyc(1'b1, 1'b0, 4'd0, 6'b110010, 1'b1, M_FETCH, 4'd4, 4'd0, 3'd5, 3'b010, "rsr2_after");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
